// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for pipeline_ctrl: per-stage stall vectors, PC reset word
// and controller state encoding.
package pipeline_ctrl_pkg;

  // Stall bit order: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX = 6'b001111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

endpackage

// File: rtl/multicycle_counter.sv
// Loadable down-counter for EX multi-cycle operations; load wins over decrement.
// Registered count, is_one decoded combinationally; saturates at zero.
module multicycle_counter #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  input  logic                 decrement,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_one
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (decrement && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign is_one = (count == CNT_WIDTH'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: combinational stall/flush vector, EX held exactly N cycles for multi-cycle ops.
// Exception flush (flush/new_pc from MEM) exists only with PIPELINE_CTRL_EXCEPTION_FLUSH_EN defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_WIDTH = 6,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_request_id,
  input  logic                   stall_request_ex,
  input  logic                   ex_multicycle_start,
  input  logic [CNT_WIDTH-1:0]   ex_multicycle_cycles,
  input  logic                   exception_input,
  input  logic [31:0]            exception_new_pc,
  output logic [STALL_WIDTH-1:0] stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   ex_multicycle_done,
  output logic                   busy
);

  state_t               state, next_state;
  logic                 cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_WIDTH-1:0] cnt_value, cnt_count;
  logic                 exc_taken;
  logic [31:0]          exc_pc;

`ifdef PIPELINE_CTRL_EXCEPTION_FLUSH_EN
  assign exc_taken = exception_input;
  assign exc_pc    = exception_new_pc;
`else
  logic unused_exc;
  assign exc_taken  = 1'b0;
  assign exc_pc     = ZERO_WORD;
  assign unused_exc = ^{exception_input, exception_new_pc};
`endif

  multicycle_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .value    (cnt_value),
    .decrement(cnt_dec),
    .count    (cnt_count),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state         = state;
    stall              = STALL_WIDTH'(STALL_NONE);
    flush              = 1'b0;
    new_pc             = ZERO_WORD;
    ex_multicycle_done = 1'b0;
    cnt_load           = 1'b0;
    cnt_value          = '0;
    cnt_dec            = 1'b0;

    if (exc_taken) begin
      // Flush outranks everything: no stall, no done, any start is dropped.
      flush      = 1'b1;
      new_pc     = exc_pc;
      cnt_load   = 1'b1;
      next_state = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (stall_request_ex || ex_multicycle_start) begin
            stall = STALL_WIDTH'(STALL_FROM_EX);
          end else if (stall_request_id) begin
            stall = STALL_WIDTH'(STALL_FROM_ID);
          end
          if (ex_multicycle_start) begin
            // A zero length still occupies EX for one cycle.
            cnt_load   = 1'b1;
            cnt_value  = (ex_multicycle_cycles == '0) ? CNT_WIDTH'(1) : ex_multicycle_cycles;
            next_state = ST_MULTI;
          end
        end
        ST_MULTI: begin
          if (cnt_count > CNT_WIDTH'(1)) begin
            stall   = STALL_WIDTH'(STALL_FROM_EX);
            cnt_dec = 1'b1;
          end else begin
            ex_multicycle_done = cnt_is_one;
            next_state         = ST_RUN;
            if (stall_request_ex) begin
              stall = STALL_WIDTH'(STALL_FROM_EX);
            end else if (stall_request_id) begin
              stall = STALL_WIDTH'(STALL_FROM_ID);
            end
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  assign busy = (state == ST_MULTI);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed stall/done/busy/flush per cycle.
module tb_pipeline_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_request_id;
  logic        stall_request_ex;
  logic        ex_multicycle_start;
  logic [5:0]  ex_multicycle_cycles;
  logic        exception_input;
  logic [31:0] exception_new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_multicycle_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.STALL_WIDTH(6), .CNT_WIDTH(6)) dut (
    .clock               (clock),
    .reset               (reset),
    .stall_request_id    (stall_request_id),
    .stall_request_ex    (stall_request_ex),
    .ex_multicycle_start (ex_multicycle_start),
    .ex_multicycle_cycles(ex_multicycle_cycles),
    .exception_input     (exception_input),
    .exception_new_pc    (exception_new_pc),
    .stall               (stall),
    .flush               (flush),
    .new_pc              (new_pc),
    .ex_multicycle_done  (ex_multicycle_done),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_done, input logic e_busy);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
    chk({tag, ".done"}, {31'd0, ex_multicycle_done}, {31'd0, e_done});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    stall_request_id = 1'b0;
    stall_request_ex = 1'b0;
    ex_multicycle_start = 1'b0;
    ex_multicycle_cycles = 6'd0;
    exception_input = 1'b0;
    exception_new_pc = 32'h0;
    #1;
    chk_out("reset", S_NONE, 1'b0, 1'b0);
    chk("reset.flush", {31'd0, flush}, 32'd0);
    chk("reset.new_pc", new_pc, 32'h0);
    tick; tick;
    reset = 1'b0;
    #1;
    chk_out("idle", S_NONE, 1'b0, 1'b0);

    // ID-only stall, then ID+EX together, then EX alone.
    stall_request_id = 1'b1; #1;
    chk_out("id_only", S_ID, 1'b0, 1'b0);
    stall_request_ex = 1'b1; #1;
    chk_out("id_ex", S_EX, 1'b0, 1'b0);
    stall_request_id = 1'b0; #1;
    chk_out("ex_only", S_EX, 1'b0, 1'b0);
    stall_request_ex = 1'b0;
    tick;

    // N=4: held cycles 0..3, done in cycle 4, busy 1..4; start/ID in MULTI ignored.
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd4; #1;
    chk_out("n4.c0", S_EX, 1'b0, 1'b0);
    tick;
    ex_multicycle_start = 1'b0; ex_multicycle_cycles = 6'd0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        stall_request_id = 1'b1;
        ex_multicycle_start = 1'b1;
        ex_multicycle_cycles = 6'd9;
      end
      #1;
      chk_out($sformatf("n4.c%0d", c), (c < 4) ? S_EX : S_NONE, c == 4, 1'b1);
      tick;
      stall_request_id = 1'b0;
      ex_multicycle_start = 1'b0;
      ex_multicycle_cycles = 6'd0;
    end
    chk_out("n4.after", S_NONE, 1'b0, 1'b0);

    // N=0 behaves as N=1.
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd0; #1;
    chk_out("n0.c0", S_EX, 1'b0, 1'b0);
    tick;
    ex_multicycle_start = 1'b0; #1;
    chk_out("n0.c1", S_NONE, 1'b1, 1'b1);
    tick;
    chk_out("n0.c2", S_NONE, 1'b0, 1'b0);

    // N=8 with exception at cycle 2.
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd8; #1;
    chk_out("n8.c0", S_EX, 1'b0, 1'b0);
    tick;
    ex_multicycle_start = 1'b0; ex_multicycle_cycles = 6'd0;
    tick;
    exception_input = 1'b1; exception_new_pc = 32'h0000_0020; #1;
`ifdef PIPELINE_CTRL_EXCEPTION_FLUSH_EN
    chk("exc.flush", {31'd0, flush}, 32'd1);
    chk("exc.new_pc", new_pc, 32'h0000_0020);
    chk_out("exc.c2", S_NONE, 1'b0, 1'b1);
    tick;
    exception_input = 1'b0; exception_new_pc = 32'h0; #1;
    chk_out("exc.c3", S_NONE, 1'b0, 1'b0);
    chk("exc.c3.flush", {31'd0, flush}, 32'd0);
    for (int c = 4; c <= 10; c++) begin
      tick;
      chk($sformatf("exc.c%0d.done", c), {31'd0, ex_multicycle_done}, 32'd0);
    end
    // Exception together with start in RUN: start dropped.
    exception_input = 1'b1; exception_new_pc = 32'h0000_0040;
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd3; #1;
    chk("exc_start.flush", {31'd0, flush}, 32'd1);
    chk("exc_start.new_pc", new_pc, 32'h0000_0040);
    chk("exc_start.stall", {26'd0, stall}, {26'd0, S_NONE});
    tick;
    exception_input = 1'b0; ex_multicycle_start = 1'b0; #1;
    chk_out("exc_start.next", S_NONE, 1'b0, 1'b0);
`else
    chk("exc.flush", {31'd0, flush}, 32'd0);
    chk("exc.new_pc", new_pc, 32'h0);
    chk_out("exc.c2", S_EX, 1'b0, 1'b1);
    tick;
    exception_input = 1'b0; exception_new_pc = 32'h0;
    for (int c = 3; c <= 8; c++) begin
      #1;
      chk_out($sformatf("exc.c%0d", c), (c < 8) ? S_EX : S_NONE, c == 8, 1'b1);
      tick;
    end
    chk_out("exc.after", S_NONE, 1'b0, 1'b0);
`endif
    tick;

    // Reset in cycle 2 of N=5 aborts; a later N=2 runs normally.
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd5; #1;
    chk_out("rst.c0", S_EX, 1'b0, 1'b0);
    tick;
    ex_multicycle_start = 1'b0; ex_multicycle_cycles = 6'd0;
    tick;
    reset = 1'b1; #1;
    chk_out("rst.c2", S_NONE, 1'b0, 1'b0);
    chk("rst.c2.flush", {31'd0, flush}, 32'd0);
    tick;
    reset = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      #1;
      chk_out($sformatf("rst.c%0d", c), S_NONE, 1'b0, 1'b0);
      tick;
    end
    ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd2; #1;
    chk_out("post.c0", S_EX, 1'b0, 1'b0);
    tick;
    ex_multicycle_start = 1'b0; ex_multicycle_cycles = 6'd0; #1;
    chk_out("post.c1", S_EX, 1'b0, 1'b1);
    tick;
    chk_out("post.c2", S_NONE, 1'b1, 1'b1);
    tick;
    chk_out("post.c3", S_NONE, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide parameter STALL_WIDTH, default 6: one stall bit per stage, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-002 SHALL provide parameter CNT_WIDTH, default 6: width of the multi-cycle length field and of the down-counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high (`ResetEnable`).
REQ-006 stall_request_id  input  1  ID stage cannot advance this cycle.
REQ-007 stall_request_ex  input  1  EX stage cannot advance this cycle.
REQ-008 ex_multicycle_start  input  1  EX begins a multi-cycle operation; single-cycle pulse.
REQ-009 ex_multicycle_cycles  input  CNT_WIDTH  operation length N; sampled with start.
REQ-010 exception_input  input  1  exception taken at MEM.
REQ-011 exception_new_pc  input  32  handler address.
REQ-012 stall  output  STALL_WIDTH  per-stage hold vector.
REQ-013 flush  output  1  clears all pipeline registers.
REQ-014 new_pc  output  32  PC load value, valid when flush=1.
REQ-015 ex_multicycle_done  output  1  one-cycle pulse: EX result ready.
REQ-016 busy  output  1  high while in state MULTI.

Function
REQ-017 SHALL implement states RUN, MULTI, held in a registered state variable.
REQ-018 SHALL drive stall, flush, new_pc and ex_multicycle_done combinationally from the state, the counter and the current inputs.
REQ-019 Stall priority (highest first): flush → 6'b000000; EX hold (stall_request_ex, start in RUN, or MULTI with counter>1) → 6'b001111; stall_request_id → 6'b000111; otherwise 6'b000000.
REQ-020 Pipeline registers SHALL insert a NOP where stall[n]=1 and stall[n+1]=0; this block only generates the vector.
REQ-021 In RUN with start=1, SHALL load counter with N, where N=0 is treated as 1, and SHALL move to MULTI.
REQ-022 In MULTI with counter>1, SHALL decrement the counter and hold stall=6'b001111.
REQ-023 In MULTI with counter==1, SHALL assert ex_multicycle_done, release the EX hold and return to RUN; EX is therefore held exactly N cycles, and done appears at cycle N after start.
REQ-024 A start received while in MULTI SHALL be ignored.
REQ-025 stall_request_id during MULTI SHALL have no effect on the vector, because the EX hold dominates.

Reset
REQ-026 On reset, SHALL set state=RUN and counter=0; outputs then read stall=0, flush=0, new_pc=`ZeroWord`, done=0, busy=0.
REQ-027 Reset asserted during MULTI SHALL abort the operation immediately, with no done pulse.

Configuration
REQ-028 SHALL support macro PIPELINE_CTRL_EXCEPTION_FLUSH_EN.
REQ-029 With PIPELINE_CTRL_EXCEPTION_FLUSH_EN defined: exception_input=1 SHALL force flush=1, new_pc=exception_new_pc and stall=0 in the same cycle, return to RUN next cycle and suppress done; a start in the same cycle SHALL be ignored.
REQ-030 With PIPELINE_CTRL_EXCEPTION_FLUSH_EN undefined: flush SHALL be tied 0, new_pc SHALL be tied `ZeroWord`, and exception_input/exception_new_pc SHALL be unused.

Structure
REQ-031 Stall-vector constants (STALL_NONE, STALL_FROM_ID, STALL_FROM_EX), the state encoding and `ZeroWord` SHALL live in the shared defines.v.
REQ-032 The down-counter SHALL be the sub-module multicycle_counter, with ports load, value, decrement, count and is_one.

Verification
REQ-033 Bench SHALL drive stall_request_id=1 alone → stall=6'b000111 and done=0.
REQ-034 Bench SHALL drive stall_request_id=1 and stall_request_ex=1 together → stall=6'b001111.
REQ-035 Bench SHALL pulse start with N=4 at cycle 0 → stall=6'b001111 in cycles 0–3, done=1 and stall=0 in cycle 4, busy=1 in cycles 1–4.
REQ-036 Bench SHALL pulse start with N=0 → same behaviour as N=1: stalled in cycle 0, done in cycle 1.
REQ-037 Bench SHALL apply exception_input=1 with exception_new_pc=0x00000020 at cycle 2 of an N=8 operation (flush macro defined) → flush=1, new_pc=0x00000020, stall=0; RUN in cycle 3; no done pulse.
REQ-038 Bench SHALL assert reset in cycle 2 of an N=5 operation → all outputs 0 immediately, and a subsequent start operates normally.
